// File: rtl/psu_seq_defs_pkg.sv
// Shared power-sequencer definitions: state encodings and default cycle counts at 2 MHz.
package psu_seq_defs_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF      = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_PS_WAIT  = 3'd2,
        ST_ON       = 3'd3,
        ST_OFF_DLY  = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    localparam int unsigned CLK_HZ                = 2_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYC      = CLK_HZ / 100_000; // 10 us
    localparam int unsigned DEF_PWROK_TIMEOUT_CYC = CLK_HZ;           // 1 s
    localparam int unsigned DEF_MIN_OFF_CYC       = CLK_HZ / 1_000;   // 1 ms

    // Largest of three cycle counts, used to size the shared counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-low reset.
module sync_2ff #(
    parameter int unsigned             WIDTH   = 1,
    parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back capture stages; q is safe to use in the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/psu_onctl_seq.sv
// PSU enable sequencer: debounces the BMC power request, enables the PSU,
// qualifies PWROK against a timeout and enforces a minimum off time.
module psu_onctl_seq
    import psu_seq_defs_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
    parameter int unsigned PWROK_TIMEOUT_CYC = DEF_PWROK_TIMEOUT_CYC,
    parameter int unsigned MIN_OFF_CYC       = DEF_MIN_OFF_CYC
) (
    input  logic               iClk_2M,
    input  logic               iRst_n,
    input  logic               FM_BMC_ONCTL_N_LATCH,
    input  logic               PWRGD_PS_PWROK,
    input  logic               iForceOff,
    output logic               FM_PS_EN,
    output logic               oPwrokQual,
    output logic               oPsFault,
    output logic [STATE_W-1:0] oState
);

    localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYC, PWROK_TIMEOUT_CYC, MIN_OFF_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(PWROK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYC - 1);

    state_t             state;
    state_t             state_nxt_c;
    logic [CNT_W-1:0]   cnt;
    logic               pwrok_s;
    logic               req_c;

    // Request is active-low on the pin; work with an active-high copy.
    assign req_c = ~FM_BMC_ONCTL_N_LATCH;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_pwrok_sync (
        .clk   (iClk_2M),
        .rst_n (iRst_n),
        .d     (PWRGD_PS_PWROK),
        .q     (pwrok_s)
    );

    // Transition rules; orderly off always outranks PWROK events.
    function automatic state_t next_state(input state_t cur, input logic req,
                                          input logic force_off, input logic pwrok,
                                          input logic [CNT_W-1:0] count);
        state_t nxt;
        nxt = cur;
        case (cur)
            ST_OFF:      if (req && !force_off) nxt = ST_DEBOUNCE;
            ST_DEBOUNCE: begin
                if (!req || force_off)      nxt = ST_OFF;
                else if (count == DEB_LAST) nxt = ST_PS_WAIT;
            end
            ST_PS_WAIT: begin
                if (force_off || !req)      nxt = ST_OFF_DLY;
                else if (pwrok)             nxt = ST_ON;
                else if (count == TO_LAST)  nxt = ST_FAULT;
            end
            ST_ON: begin
                if (force_off || !req)      nxt = ST_OFF_DLY;
                else if (!pwrok)            nxt = ST_FAULT;
            end
            ST_OFF_DLY:  if (count == OFF_LAST) nxt = ST_OFF;
            ST_FAULT:    if (!req) nxt = ST_OFF_DLY;
            default:     nxt = ST_OFF;
        endcase
        return nxt;
    endfunction

    assign state_nxt_c = next_state(state, req_c, iForceOff, pwrok_s, cnt);

    // State, shared dwell counter and outputs decoded from the next state.
    always_ff @(posedge iClk_2M) begin
        if (!iRst_n) begin
            state      <= ST_OFF;
            cnt        <= '0;
            FM_PS_EN   <= 1'b0;
            oPwrokQual <= 1'b0;
            oPsFault   <= 1'b0;
        end else begin
            state <= state_nxt_c;
            if (state_nxt_c != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            FM_PS_EN   <= (state_nxt_c == ST_PS_WAIT) || (state_nxt_c == ST_ON);
            oPwrokQual <= (state_nxt_c == ST_ON);
            oPsFault   <= (state_nxt_c == ST_FAULT);
        end
    end

    assign oState = state;

endmodule

// File: tb/tb_psu_onctl_seq.sv
// Self-checking bench for psu_onctl_seq: directed scenarios plus a randomized
// run compared against a timestamp-based behavioural model.
module tb_psu_onctl_seq;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TOUT = 100;
    localparam int unsigned MINO = 10;

    localparam int S_OFF = 0, S_DEB = 1, S_WAIT = 2, S_ON = 3, S_DLY = 4, S_FLT = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_n = 1'b1;
    logic       pwrok = 1'b0;
    logic       force_off = 1'b0;
    logic       ps_en;
    logic       pwrok_qual;
    logic       ps_fault;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: current state, edge at which it was entered, PWROK input history.
    int   m_st    = 0;
    int   m_entry = 0;
    logic pw_hist[$];

    psu_onctl_seq #(
        .DEBOUNCE_CYC      (DEB),
        .PWROK_TIMEOUT_CYC (TOUT),
        .MIN_OFF_CYC       (MINO)
    ) dut (
        .iClk_2M              (clk),
        .iRst_n               (rst_n),
        .FM_BMC_ONCTL_N_LATCH (req_n),
        .PWRGD_PS_PWROK       (pwrok),
        .iForceOff            (force_off),
        .FM_PS_EN             (ps_en),
        .oPwrokQual           (pwrok_qual),
        .oPsFault             (ps_fault),
        .oState               (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural model advanced once per clock edge with the sampled inputs.
    task automatic model_edge(input logic r, input logic rq_n, input logic fo, input logic pw);
        logic ps;
        logic rq;
        int   nx;
        if (!r) begin
            m_st    = S_OFF;
            m_entry = cyc;
            pw_hist.delete();
            return;
        end
        ps = (pw_hist.size() >= 2) ? pw_hist[pw_hist.size()-2] : 1'b0;
        rq = ~rq_n;
        nx = m_st;
        case (m_st)
            S_OFF:  if (rq && !fo) nx = S_DEB;
            S_DEB:  if (!rq || fo) nx = S_OFF;
                    else if (cyc == m_entry + int'(DEB)) nx = S_WAIT;
            S_WAIT: if (!rq || fo) nx = S_DLY;
                    else if (ps) nx = S_ON;
                    else if (cyc == m_entry + int'(TOUT)) nx = S_FLT;
            S_ON:   if (!rq || fo) nx = S_DLY;
                    else if (!ps) nx = S_FLT;
            S_DLY:  if (cyc == m_entry + int'(MINO)) nx = S_OFF;
            S_FLT:  if (!rq) nx = S_DLY;
            default: nx = S_OFF;
        endcase
        if (nx != m_st) begin
            m_st    = nx;
            m_entry = cyc;
        end
        pw_hist.push_back(pw);
        if (pw_hist.size() > 3) void'(pw_hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_edge(rst_n, req_n, force_off, pwrok);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_n = 1'b1; pwrok = 1'b0; force_off = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Drives the request low with PWROK high and waits for the ON state.
    task automatic power_on(output bit ok);
        req_n = 1'b0;
        pwrok = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (state == 3'd3) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ps_en !== 1'b0)      begin errors++; $display("FAIL reset_en got=%b exp=0", ps_en); end
        checks++; if (pwrok_qual !== 1'b0) begin errors++; $display("FAIL reset_qual got=%b exp=0", pwrok_qual); end
        checks++; if (ps_fault !== 1'b0)   begin errors++; $display("FAIL reset_fault got=%b exp=0", ps_fault); end
        checks++; if (state !== 3'd0)      begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    endtask

    task automatic test_nominal();
        do_reset();
        req_n = 1'b0;
        tick(); // edge 0
        for (int e = 1; e <= 22; e++) begin
            if (e == 20) pwrok = 1'b1;
            tick();
            checks++;
            if (ps_en !== (e >= 4)) begin errors++; $display("FAIL nominal_en edge=%0d got=%b exp=%b", e, ps_en, (e >= 4)); end
            checks++;
            if (pwrok_qual !== (e >= 22)) begin errors++; $display("FAIL nominal_qual edge=%0d got=%b exp=%b", e, pwrok_qual, (e >= 22)); end
        end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL nominal_state got=%0d exp=3", state); end
    endtask

    task automatic test_glitch();
        do_reset();
        req_n = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++; if (ps_en !== 1'b0) begin errors++; $display("FAIL glitch_en edge=%0d got=%b exp=0", e, ps_en); end
        end
        req_n = 1'b1;
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL glitch_state got=%0d exp=0", state); end
        checks++; if (ps_en !== 1'b0) begin errors++; $display("FAIL glitch_en_hi got=%b exp=0", ps_en); end
        // A fresh fall must again wait the full debounce.
        req_n = 1'b0;
        tick();
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (ps_en !== (e == 4)) begin errors++; $display("FAIL glitch_restart edge=%0d got=%b exp=%b", e, ps_en, (e == 4)); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_n = 1'b0;
        pwrok = 1'b0;
        tick(); // edge 0, PS_WAIT entered at edge 4
        for (int e = 1; e <= 104; e++) begin
            tick();
            if (e == 103) begin
                checks++; if (state !== 3'd2 || ps_fault !== 1'b0) begin errors++; $display("FAIL timeout_early state=%0d fault=%b exp state=2 fault=0", state, ps_fault); end
            end
        end
        checks++; if (ps_fault !== 1'b1) begin errors++; $display("FAIL timeout_fault got=%b exp=1", ps_fault); end
        checks++; if (ps_en !== 1'b0)    begin errors++; $display("FAIL timeout_en got=%b exp=0", ps_en); end
        checks++; if (state !== 3'd5)    begin errors++; $display("FAIL timeout_state got=%0d exp=5", state); end
        force_off = 1'b1;
        for (int e = 0; e < 5; e++) tick();
        force_off = 1'b0;
        checks++; if (ps_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got=%b exp=1", ps_fault); end
        req_n = 1'b1;
        tick();
        checks++; if (state !== 3'd4 || ps_fault !== 1'b0) begin errors++; $display("FAIL fault_exit state=%0d fault=%b exp state=4 fault=0", state, ps_fault); end
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 9) begin
                checks++; if (state !== 3'd4) begin errors++; $display("FAIL fault_dly9 got=%0d exp=4", state); end
            end
        end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL fault_dly10 got=%0d exp=0", state); end
    endtask

    task automatic test_loss_vs_off();
        bit ok;
        do_reset();
        power_on(ok);
        checks++; if (!ok) begin errors++; $display("FAIL loss_power_on got=timeout exp=ON"); end
        pwrok = 1'b0;
        req_n = 1'b1;
        tick();
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL off_wins_state got=%0d exp=4", state); end
        checks++; if (ps_en !== 1'b0) begin errors++; $display("FAIL off_wins_en got=%b exp=0", ps_en); end
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++; if (ps_fault !== 1'b0) begin errors++; $display("FAIL off_wins_fault edge=%0d got=%b exp=0", e, ps_fault); end
            if (e == 9) begin
                checks++; if (state !== 3'd4) begin errors++; $display("FAIL off_wins_dly9 got=%0d exp=4", state); end
            end
        end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL off_wins_dly10 got=%0d exp=0", state); end
        power_on(ok);
        checks++; if (!ok) begin errors++; $display("FAIL loss2_power_on got=timeout exp=ON"); end
        pwrok = 1'b0;
        for (int e = 0; e <= 2; e++) begin
            tick();
            checks++;
            if (ps_fault !== (e == 2)) begin errors++; $display("FAIL loss_fault edge=%0d got=%b exp=%b", e, ps_fault, (e == 2)); end
            checks++;
            if (ps_en !== (e != 2)) begin errors++; $display("FAIL loss_en edge=%0d got=%b exp=%b", e, ps_en, (e != 2)); end
        end
    endtask

    task automatic test_min_off();
        bit ok;
        do_reset();
        power_on(ok);
        checks++; if (!ok) begin errors++; $display("FAIL minoff_power_on got=timeout exp=ON"); end
        req_n = 1'b1;
        tick(); // edge D
        checks++; if (ps_en !== 1'b0) begin errors++; $display("FAIL minoff_drop got=%b exp=0", ps_en); end
        tick(); // D+1
        req_n = 1'b0;
        for (int e = 2; e <= 15; e++) begin
            tick();
            checks++;
            if (ps_en !== (e == 15)) begin errors++; $display("FAIL minoff_en edge=D+%0d got=%b exp=%b", e, ps_en, (e == 15)); end
        end
    endtask

    task automatic test_reset_mid_on();
        bit ok;
        do_reset();
        power_on(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rston_power_on got=timeout exp=ON"); end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({ps_en, pwrok_qual, ps_fault, state} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_on en=%b qual=%b fault=%b state=%0d exp all 0", ps_en, pwrok_qual, ps_fault, state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_force_off();
        bit seen;
        do_reset();
        req_n = 1'b0;
        pwrok = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (state == 3'd2) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL force_reach_wait got=timeout exp=PS_WAIT"); end
        force_off = 1'b1;
        tick();
        force_off = 1'b0;
        checks++; if (ps_en !== 1'b0) begin errors++; $display("FAIL force_en got=%b exp=0", ps_en); end
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL force_state got=%0d exp=4", state); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39, 0) == 0) req_n = ~req_n;
            if ($urandom_range(29, 0) == 0) pwrok = ~pwrok;
            force_off = ($urandom_range(199, 0) == 0);
            rst_n     = ($urandom_range(499, 0) != 0);
            tick();
            checks++;
            if (state !== 3'(m_st)) begin errors++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", cyc, state, m_st); end
            checks++;
            if (ps_en !== (m_st == S_WAIT || m_st == S_ON)) begin errors++; $display("FAIL rand_en cyc=%0d got=%b exp=%b", cyc, ps_en, (m_st == S_WAIT || m_st == S_ON)); end
            checks++;
            if (pwrok_qual !== (m_st == S_ON)) begin errors++; $display("FAIL rand_qual cyc=%0d got=%b exp=%b", cyc, pwrok_qual, (m_st == S_ON)); end
            checks++;
            if (ps_fault !== (m_st == S_FLT)) begin errors++; $display("FAIL rand_fault cyc=%0d got=%b exp=%b", cyc, ps_fault, (m_st == S_FLT)); end
        end
        rst_n = 1'b1;
        force_off = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout();
        test_loss_vs_off();
        test_min_off();
        test_reset_mid_on();
        test_force_off();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
